sid_regs: RTL and testbench

- CPU-side register interface of the SID: the write/read end of the same path whose far end is the waveform generator.
- Decodes host bus writes into the per-voice control fields that feed the waveform generators (frequency, pulse width, control bits), the envelope and the filter.
- Returns the read-only registers (OSC3, ENV3, POTX, POTY) on host reads.
- Models the SID data-bus latch: a read of a write-only address returns the last bus value, which decays to zero after a programmable idle time.

---
 rtl/sid_pkg.sv | 66 ++++++
 rtl/sid_bus_latch.sv | 55 +++++
 rtl/sid_regs.sv | 145 ++++++++++++++
 tb/tb_sid_regs.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/sid_pkg.sv
// Shared register-map constants, per-voice register struct and address decode
// for the SID host register interface.
package sid_pkg;

    localparam logic [4:0] REG_FREQ_LO  = 5'h00;
    localparam logic [4:0] REG_FREQ_HI  = 5'h01;
    localparam logic [4:0] REG_PW_LO    = 5'h02;
    localparam logic [4:0] REG_PW_HI    = 5'h03;
    localparam logic [4:0] REG_CTRL     = 5'h04;
    localparam logic [4:0] REG_AD       = 5'h05;
    localparam logic [4:0] REG_SR       = 5'h06;
    localparam logic [4:0] REG_FC_LO    = 5'h15;
    localparam logic [4:0] REG_FC_HI    = 5'h16;
    localparam logic [4:0] REG_RES_FILT = 5'h17;
    localparam logic [4:0] REG_MODE_VOL = 5'h18;
    localparam logic [4:0] REG_POTX     = 5'h19;
    localparam logic [4:0] REG_POTY     = 5'h1A;
    localparam logic [4:0] REG_OSC3     = 5'h1B;
    localparam logic [4:0] REG_ENV3     = 5'h1C;
    localparam logic [4:0] VOICE_STRIDE = 5'd7;

    localparam int CTRL_NOISE = 7;
    localparam int CTRL_PULSE = 6;
    localparam int CTRL_SAW   = 5;
    localparam int CTRL_TRI   = 4;
    localparam int CTRL_TEST  = 3;
    localparam int CTRL_RING  = 2;
    localparam int CTRL_SYNC  = 1;
    localparam int CTRL_GATE  = 0;

    typedef struct packed {
        logic [15:0] freq;
        logic [11:0] pw;
        logic [7:0]  ctrl;
        logic [7:0]  ad;
        logic [7:0]  sr;
    } voice_regs_t;

    typedef struct packed {
        logic       hit;
        logic [1:0] voice;
        logic [4:0] off;
    } voice_sel_t;

    // Split a bus address into voice index and offset within that voice's block.
    function automatic voice_sel_t decode_voice(input logic [4:0] addr);
        voice_sel_t s;
        s.hit = 1'b1;
        if (addr < VOICE_STRIDE) begin
            s.voice = 2'd0;
            s.off   = addr;
        end else if (addr < 5'(2 * VOICE_STRIDE)) begin
            s.voice = 2'd1;
            s.off   = addr - VOICE_STRIDE;
        end else if (addr < 5'(3 * VOICE_STRIDE)) begin
            s.voice = 2'd2;
            s.off   = addr - 5'(2 * VOICE_STRIDE);
        end else begin
            s.hit   = 1'b0;
            s.voice = 2'd0;
            s.off   = 5'd0;
        end
        return s;
    endfunction

endpackage

// File: rtl/sid_bus_latch.sv
// SID data-bus latch: holds the last bus value and clears it after a
// programmable number of idle cycles.
module sid_bus_latch
    import sid_pkg::*;
#(
    parameter int                 DECAY_W      = 16,
    parameter logic [DECAY_W-1:0] DECAY_CYCLES = 16'd8000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_i,
    input  logic [7:0] value_i,
    output logic [7:0] latch_o
);

    localparam logic [DECAY_W-1:0] CNT_ONE  = DECAY_W'(1);
    localparam logic [DECAY_W-1:0] CNT_ZERO = DECAY_W'(0);

    logic [7:0]         latch_q, latch_d;
    logic [DECAY_W-1:0] count_q, count_d;

    // An access always wins over the terminal count in the same cycle.
    always_comb begin
        latch_d = latch_q;
        count_d = count_q;
        if (load_i) begin
            latch_d = value_i;
            count_d = DECAY_CYCLES;
        end else if (count_q != CNT_ZERO) begin
            count_d = count_q - CNT_ONE;
            if (count_q == CNT_ONE) begin
                latch_d = 8'h00;
            end else begin
                latch_d = latch_q;
            end
        end else begin
            latch_d = latch_q;
            count_d = count_q;
        end
    end

    // Latch and decay counter state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            latch_q <= 8'h00;
            count_q <= CNT_ZERO;
        end else begin
            latch_q <= latch_d;
            count_q <= count_d;
        end
    end

    assign latch_o = latch_q;

endmodule

// File: rtl/sid_regs.sv
// SID host register interface: decodes writes into voice/filter control
// registers and serves read-only registers and the decaying bus latch.
module sid_regs
    import sid_pkg::*;
#(
    parameter int                 DECAY_W      = 16,
    parameter logic [DECAY_W-1:0] DECAY_CYCLES = 16'd8000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        bus_en,
    input  logic        bus_rw,
    input  logic [4:0]  bus_addr,
    input  logic [7:0]  bus_wdata,
    output logic [7:0]  bus_rdata,
    output logic        bus_rvalid,
    input  logic [11:0] osc3_in,
    input  logic [7:0]  env3_in,
    input  logic [7:0]  potx_in,
    input  logic [7:0]  poty_in,
    output logic [47:0] freq_o,
    output logic [35:0] pw_o,
    output logic [23:0] ctrl_o,
    output logic [23:0] ad_o,
    output logic [23:0] sr_o,
    output logic [10:0] fc_o,
    output logic [7:0]  res_filt_o,
    output logic [7:0]  mode_vol_o
);

    voice_regs_t voice_q [3];
    voice_regs_t voice_d [3];
    logic [2:0]  fc_lo_q, fc_lo_d;
    logic [7:0]  fc_hi_q, fc_hi_d;
    logic [7:0]  res_filt_q, res_filt_d;
    logic [7:0]  mode_vol_q, mode_vol_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        rvalid_q, rvalid_d;

    logic        wr_s, rd_s;
    voice_sel_t  sel_s;
    logic [7:0]  osc3_msb_s, rd_value_s, latch_s, load_value_s;

    assign wr_s       = bus_en & ~bus_rw;
    assign rd_s       = bus_en & bus_rw;
    assign sel_s      = decode_voice(bus_addr);
    assign osc3_msb_s = 8'(osc3_in >> 4);

    // Write decode; FREQ/PW halves are independent bytes with no staging.
    always_comb begin
        voice_d    = voice_q;
        fc_lo_d    = fc_lo_q;
        fc_hi_d    = fc_hi_q;
        res_filt_d = res_filt_q;
        mode_vol_d = mode_vol_q;
        if (wr_s) begin
            for (int v = 0; v < 3; v++) begin
                if (sel_s.hit && (sel_s.voice == 2'(v))) begin
                    case (sel_s.off)
                        REG_FREQ_LO: voice_d[v].freq[7:0]  = bus_wdata;
                        REG_FREQ_HI: voice_d[v].freq[15:8] = bus_wdata;
                        REG_PW_LO:   voice_d[v].pw[7:0]    = bus_wdata;
                        REG_PW_HI:   voice_d[v].pw[11:8]   = bus_wdata[3:0];
                        REG_CTRL:    voice_d[v].ctrl       = bus_wdata;
                        REG_AD:      voice_d[v].ad         = bus_wdata;
                        REG_SR:      voice_d[v].sr         = bus_wdata;
                        default:     voice_d[v]            = voice_q[v];
                    endcase
                end else begin
                    voice_d[v] = voice_q[v];
                end
            end
            case (bus_addr)
                REG_FC_LO:    fc_lo_d    = bus_wdata[2:0];
                REG_FC_HI:    fc_hi_d    = bus_wdata;
                REG_RES_FILT: res_filt_d = bus_wdata;
                REG_MODE_VOL: mode_vol_d = bus_wdata;
                default:      fc_lo_d    = fc_lo_q;
            endcase
        end else begin
            voice_d = voice_q;
            fc_lo_d = fc_lo_q;
        end
    end

    // Read mux: live inputs for the read-only registers, latch for the rest.
    always_comb begin
        case (bus_addr)
            REG_POTX: rd_value_s = potx_in;
            REG_POTY: rd_value_s = poty_in;
            REG_OSC3: rd_value_s = osc3_msb_s;
            REG_ENV3: rd_value_s = env3_in;
            default:  rd_value_s = latch_s;
        endcase
        rvalid_d     = rd_s;
        rdata_d      = rd_s ? rd_value_s : rdata_q;
        load_value_s = bus_rw ? rd_value_s : bus_wdata;
    end

    // Register file and read-return state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int v = 0; v < 3; v++) begin
                voice_q[v] <= '0;
            end
            fc_lo_q    <= 3'd0;
            fc_hi_q    <= 8'h00;
            res_filt_q <= 8'h00;
            mode_vol_q <= 8'h00;
            rdata_q    <= 8'h00;
            rvalid_q   <= 1'b0;
        end else begin
            voice_q    <= voice_d;
            fc_lo_q    <= fc_lo_d;
            fc_hi_q    <= fc_hi_d;
            res_filt_q <= res_filt_d;
            mode_vol_q <= mode_vol_d;
            rdata_q    <= rdata_d;
            rvalid_q   <= rvalid_d;
        end
    end

    sid_bus_latch #(
        .DECAY_W      (DECAY_W),
        .DECAY_CYCLES (DECAY_CYCLES)
    ) u_latch (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (bus_en),
        .value_i (load_value_s),
        .latch_o (latch_s)
    );

    assign freq_o     = {voice_q[2].freq, voice_q[1].freq, voice_q[0].freq};
    assign pw_o       = {voice_q[2].pw,   voice_q[1].pw,   voice_q[0].pw};
    assign ctrl_o     = {voice_q[2].ctrl, voice_q[1].ctrl, voice_q[0].ctrl};
    assign ad_o       = {voice_q[2].ad,   voice_q[1].ad,   voice_q[0].ad};
    assign sr_o       = {voice_q[2].sr,   voice_q[1].sr,   voice_q[0].sr};
    assign fc_o       = {fc_hi_q, fc_lo_q};
    assign res_filt_o = res_filt_q;
    assign mode_vol_o = mode_vol_q;
    assign bus_rdata  = rdata_q;
    assign bus_rvalid = rvalid_q;

endmodule

// File: tb/tb_sid_regs.sv
// Self-checking bench for sid_regs: directed scenarios plus random bus traffic
// compared against a byte-array model of the register map and bus latch.
module tb_sid_regs;

    localparam logic [15:0] DECAY = 16'd4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        bus_en, bus_rw;
    logic [4:0]  bus_addr;
    logic [7:0]  bus_wdata, bus_rdata;
    logic        bus_rvalid;
    logic [11:0] osc3_in;
    logic [7:0]  env3_in, potx_in, poty_in;
    logic [47:0] freq_o;
    logic [35:0] pw_o;
    logic [23:0] ctrl_o, ad_o, sr_o;
    logic [10:0] fc_o;
    logic [7:0]  res_filt_o, mode_vol_o;

    always #5 clk = ~clk;

    sid_regs #(.DECAY_W(16), .DECAY_CYCLES(DECAY)) dut (
        .clk(clk), .rst_n(rst_n), .bus_en(bus_en), .bus_rw(bus_rw),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
        .bus_rvalid(bus_rvalid), .osc3_in(osc3_in), .env3_in(env3_in),
        .potx_in(potx_in), .poty_in(poty_in), .freq_o(freq_o), .pw_o(pw_o),
        .ctrl_o(ctrl_o), .ad_o(ad_o), .sr_o(sr_o), .fc_o(fc_o),
        .res_filt_o(res_filt_o), .mode_vol_o(mode_vol_o)
    );

    // Model: register bytes by address, last bus value, idle edges since last access.
    logic [7:0] mem [0:31];
    logic [7:0] m_last, m_rdata;
    logic       m_rvalid;
    int         m_idle;
    int         n_cmp = 0;
    int         n_fail = 0;

    task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mem[i] = 8'h00;
        m_last   = 8'h00;
        m_rdata  = 8'h00;
        m_rvalid = 1'b0;
        m_idle   = 0;
    endtask

    function automatic logic [7:0] model_latch();
        return (m_idle >= int'(DECAY)) ? 8'h00 : m_last;
    endfunction

    task automatic check_all();
        logic [47:0] e_freq;
        logic [35:0] e_pw;
        logic [23:0] e_ctrl, e_ad, e_sr;
        logic [7:0]  pwh;
        for (int v = 0; v < 3; v++) begin
            pwh = mem[7*v+3];
            e_freq[16*v +: 16] = {mem[7*v+1], mem[7*v]};
            e_pw[12*v +: 12]   = {pwh[3:0], mem[7*v+2]};
            e_ctrl[8*v +: 8]   = mem[7*v+4];
            e_ad[8*v +: 8]     = mem[7*v+5];
            e_sr[8*v +: 8]     = mem[7*v+6];
        end
        pwh = mem[21];
        check("rvalid",   bus_rvalid, m_rvalid);
        check("rdata",    bus_rdata,  m_rdata);
        check("freq",     freq_o,     e_freq);
        check("pw",       pw_o,       e_pw);
        check("ctrl",     ctrl_o,     e_ctrl);
        check("ad",       ad_o,       e_ad);
        check("sr",       sr_o,       e_sr);
        check("fc",       fc_o,       {mem[22], pwh[2:0]});
        check("res_filt", res_filt_o, mem[23]);
        check("mode_vol", mode_vol_o, mem[24]);
    endtask

    // One bus cycle: drive at negedge, update the model, sample 1 time unit after posedge.
    task automatic step(input logic en, input logic rw, input logic [4:0] addr, input logic [7:0] wdata);
        logic [7:0] val;
        @(negedge clk);
        bus_en = en; bus_rw = rw; bus_addr = addr; bus_wdata = wdata;
        m_rvalid = 1'b0;
        if (en) begin
            if (rw) begin
                case (addr)
                    5'h19:   val = potx_in;
                    5'h1A:   val = poty_in;
                    5'h1B:   val = osc3_in[11:4];
                    5'h1C:   val = env3_in;
                    default: val = model_latch();
                endcase
                m_rdata  = val;
                m_rvalid = 1'b1;
                m_last   = val;
            end else begin
                if (addr <= 5'h18) mem[addr] = wdata;
                m_last = wdata;
            end
            m_idle = 0;
        end else begin
            m_idle++;
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 5'h00, 8'h00);
    endtask

    initial begin
        rst_n = 1'b0; bus_en = 1'b0; bus_rw = 1'b0; bus_addr = 5'h00; bus_wdata = 8'h00;
        osc3_in = 12'h000; env3_in = 8'h00; potx_in = 8'h00; poty_in = 8'h00;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // Frequency bytes of voice 1
        step(1'b1, 1'b0, 5'h00, 8'h34);
        step(1'b1, 1'b0, 5'h01, 8'h12);
        check("freq_v1", freq_o[15:0], 16'h1234);

        // Voice 2 PW_HI keeps only the low nibble; read back via latch
        step(1'b1, 1'b0, 5'h0A, 8'hFF);
        check("pw_v2", pw_o[23:12], 12'hF00);
        step(1'b1, 1'b1, 5'h0A, 8'h00);
        check("pw_hi_latch", bus_rdata, 8'hFF);

        // OSC3 read returns the top 8 bits, then latches
        osc3_in = 12'hABC;
        step(1'b1, 1'b1, 5'h1B, 8'h00);
        check("osc3", bus_rdata, 8'hAB);
        step(1'b1, 1'b1, 5'h00, 8'h00);
        check("osc3_latch", bus_rdata, 8'hAB);

        // Decay boundary: 3 idle cycles keep the value, 4 clear it
        step(1'b1, 1'b0, 5'h05, 8'h5A);
        idle(3);
        step(1'b1, 1'b1, 5'h05, 8'h00);
        check("decay_keep", bus_rdata, 8'h5A);
        step(1'b1, 1'b0, 5'h05, 8'h5A);
        idle(4);
        step(1'b1, 1'b1, 5'h05, 8'h00);
        check("decay_clear", bus_rdata, 8'h00);

        // Access on the terminal-count cycle wins and reloads
        step(1'b1, 1'b0, 5'h06, 8'h11);
        idle(3);
        env3_in = 8'h77;
        step(1'b1, 1'b1, 5'h1C, 8'h00);
        check("env3_tc", bus_rdata, 8'h77);
        idle(3);
        step(1'b1, 1'b1, 5'h00, 8'h00);
        check("env3_reload", bus_rdata, 8'h77);

        // Write to an unused address only loads the latch
        step(1'b1, 1'b0, 5'h1D, 8'h99);
        step(1'b1, 1'b1, 5'h02, 8'h00);
        check("unused_wr_latch", bus_rdata, 8'h99);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            osc3_in = 12'($urandom);
            env3_in = 8'($urandom);
            potx_in = 8'($urandom);
            poty_in = 8'($urandom);
            if ($urandom_range(0, 9) == 0) begin
                idle($urandom_range(3, 6));
            end else begin
                step(1'($urandom_range(0, 2) != 0), 1'($urandom), 5'($urandom), 8'($urandom));
            end
        end

        // Reset during an in-flight read
        step(1'b1, 1'b0, 5'h18, 8'h0F);
        check("mode_vol_wr", mode_vol_o, 8'h0F);
        @(negedge clk);
        bus_en = 1'b1; bus_rw = 1'b1; bus_addr = 5'h00;
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_mode_vol", mode_vol_o, 8'h00);
        check("rst_async_rvalid", bus_rvalid, 1'b0);
        @(posedge clk);
        #1;
        check("rst_hold_rvalid", bus_rvalid, 1'b0);
        @(negedge clk);
        bus_en = 1'b0;
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        check_all();
        step(1'b1, 1'b1, 5'h03, 8'h00);
        check("rst_latch_zero", bus_rdata, 8'h00);
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
